// File: rtl/avg_pkg.sv
// Shared constants and width helpers for the pipelined N-input averager.
// Used by the RTL and by its testbench.
package avg_pkg;

  localparam int unsigned ROUND_TRUNC   = 0;
  localparam int unsigned ROUND_HALF_UP = 1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Total right shift applied to the accumulator: tree depth plus beats.
  function automatic int unsigned shift_amt(input int unsigned num_inputs,
                                            input int unsigned log2_beats);
    return clog2(num_inputs) + log2_beats;
  endfunction

  function automatic int unsigned acc_width(input int unsigned dwidth,
                                            input int unsigned num_inputs,
                                            input int unsigned log2_beats);
    return dwidth + shift_amt(num_inputs, log2_beats);
  endfunction

  // Width of tree level j (level 0 is the raw input vector).
  function automatic int unsigned level_width(input int unsigned num_inputs,
                                              input int unsigned dwidth,
                                              input int unsigned j);
    return (num_inputs >> j) * (dwidth + j);
  endfunction

  // Bit offset of tree level j inside the flattened level bus.
  function automatic int unsigned level_offset(input int unsigned num_inputs,
                                               input int unsigned dwidth,
                                               input int unsigned j);
    int unsigned o;
    o = 0;
    for (int unsigned i = 0; i < j; i++) begin
      o += level_width(num_inputs, dwidth, i);
    end
    return o;
  endfunction

endpackage

// File: rtl/avg_add_stage.sv
// One registered adder-tree level: N samples of width W in, N/2 pair sums of
// width W+1 out, with a valid bit that travels alongside the data.
module avg_add_stage
  import avg_pkg::*;
#(
  parameter int unsigned N      = 2,
  parameter int unsigned W      = 16,
  parameter int unsigned SIGNED = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   clear,
  input  logic [N*W-1:0]         in_dat,
  input  logic                   in_valid,
  output logic [(N/2)*(W+1)-1:0] out_dat,
  output logic                   out_valid
);

  localparam int unsigned NO = N / 2;

  logic [NO*(W+1)-1:0] sum_d;

  function automatic logic [W:0] ext(input logic [W-1:0] x);
    return {(SIGNED != 0) & x[W-1], x};
  endfunction

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < NO; k++) begin
      sum_d[k*(W+1) +: W+1] = ext(in_dat[2*k*W +: W]) + ext(in_dat[(2*k+1)*W +: W]);
    end
  end

  // Clear drops the valid bit even while the pipeline is frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_dat   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (clear) begin
        out_valid <= 1'b0;
      end else if (en) begin
        out_valid <= in_valid;
      end
      if (en && in_valid) begin
        out_dat <= sum_d;
      end
    end
  end

endmodule

// File: rtl/avg_n_per_clk_pipe.sv
// Pipelined averager: registered adder tree per beat, then accumulation of
// 2**LOG2_BEATS tree sums into one rounded average with ready/valid on both sides.
module avg_n_per_clk_pipe
  import avg_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 16,
  parameter int unsigned DWIDTH     = 16,
  parameter int unsigned LOG2_BEATS = 0,
  parameter int unsigned SIGNED     = 0,
  parameter int unsigned ROUND      = ROUND_TRUNC
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_INPUTS*DWIDTH-1:0] i_dat_vector,
  input  logic                         i_dat_valid,
  output logic                         i_dat_ready,
  input  logic                         i_clear,
  output logic [DWIDTH-1:0]            o_avg,
  output logic                         o_avg_valid,
  input  logic                         o_avg_ready
);

  localparam int unsigned L     = clog2(NUM_INPUTS);
  localparam int unsigned S     = shift_amt(NUM_INPUTS, LOG2_BEATS);
  localparam int unsigned AW    = acc_width(DWIDTH, NUM_INPUTS, LOG2_BEATS);
  localparam int unsigned TW    = DWIDTH + L;
  localparam int unsigned CW    = (LOG2_BEATS > 0) ? LOG2_BEATS : 1;
  localparam int unsigned BEATS = 1 << LOG2_BEATS;
  localparam int unsigned BUS_W = level_offset(NUM_INPUTS, DWIDTH, L + 1);

  logic en;
  logic beat_in;

  assign en          = !o_avg_valid || o_avg_ready;
  assign i_dat_ready = en && !i_clear;
  assign beat_in     = i_dat_valid && i_dat_ready;

  // Level 0 of the bus is the raw input; level j holds the output of stage j.
  logic [BUS_W-1:0] lvl_dat;
  logic [L:0]       lvl_vld;

  assign lvl_dat[level_width(NUM_INPUTS, DWIDTH, 0)-1:0] = i_dat_vector;
  assign lvl_vld[0] = beat_in;

  for (genvar j = 0; j < L; j++) begin : g_lvl
    localparam int unsigned IO = level_offset(NUM_INPUTS, DWIDTH, j);
    localparam int unsigned IW = level_width(NUM_INPUTS, DWIDTH, j);
    localparam int unsigned OO = level_offset(NUM_INPUTS, DWIDTH, j + 1);
    localparam int unsigned OW = level_width(NUM_INPUTS, DWIDTH, j + 1);

    avg_add_stage #(
      .N      (NUM_INPUTS >> j),
      .W      (DWIDTH + j),
      .SIGNED (SIGNED)
    ) u_add (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .clear     (i_clear),
      .in_dat    (lvl_dat[IO +: IW]),
      .in_valid  (lvl_vld[j]),
      .out_dat   (lvl_dat[OO +: OW]),
      .out_valid (lvl_vld[j+1])
    );
  end

  logic [TW-1:0] tree_sum;
  logic          tree_vld;

  assign tree_sum = lvl_dat[level_offset(NUM_INPUTS, DWIDTH, L) +: TW];
  assign tree_vld = lvl_vld[L];

  logic [AW-1:0] acc_q;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] tree_ext;
  logic [AW-1:0] total;
  logic [AW-1:0] bias;
  logic [AW-1:0] rounded;
  logic [DWIDTH-1:0] avg_next;
  logic          last;

  always_comb begin
    if (SIGNED != 0) begin
      tree_ext = AW'($signed(tree_sum));
    end else begin
      tree_ext = AW'(tree_sum);
    end
  end

  // The rounded total always fits in AW bits, so the low bits of the shift
  // are the result for both signed (floor) and unsigned data.
  assign bias     = (ROUND == ROUND_HALF_UP) ? (AW'(1) << (S - 1)) : '0;
  assign total    = acc_q + tree_ext;
  assign rounded  = total + bias;
  assign avg_next = DWIDTH'(rounded >> S);
  assign last     = (cnt_q == CW'(BEATS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      o_avg       <= '0;
      o_avg_valid <= 1'b0;
    end else begin
      if (i_clear) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else if (en && tree_vld) begin
        if (last) begin
          acc_q <= '0;
          cnt_q <= '0;
        end else begin
          acc_q <= total;
          cnt_q <= cnt_q + CW'(1);
        end
      end
      // With en high any presented result is being accepted this cycle.
      if (en) begin
        if (tree_vld && last && !i_clear) begin
          o_avg       <= avg_next;
          o_avg_valid <= 1'b1;
        end else begin
          o_avg_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_avg_n_per_clk_pipe.sv
// Bench for avg_n_per_clk_pipe: four parameter sets, each with a driver that
// pushes expected averages into a queue and a monitor that pops on handshake.
module tb_avg_n_per_clk_pipe;
  import avg_pkg::*;

  localparam int unsigned NI    = 16;
  localparam int unsigned DW    = 16;
  localparam int unsigned NCFG  = 4;
  localparam int unsigned NRAND = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bad(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  task automatic mark_done();
    n_done++;
  endtask

  function automatic logic [NI*DW-1:0] mk(input logic [DW-1:0] lo, input logic [DW-1:0] hi,
                                          input int nlo);
    logic [NI*DW-1:0] v;
    for (int k = 0; k < NI; k++) v[k*DW +: DW] = (k < nlo) ? lo : hi;
    return v;
  endfunction

  for (genvar c = 0; c < NCFG; c++) begin : g_cfg
    localparam int unsigned L2B   = (c >= 2) ? 2 : 0;
    localparam int unsigned SG    = c % 2;
    localparam int unsigned RD    = (c == 1 || c == 2) ? 1 : 0;
    localparam int unsigned S     = shift_amt(NI, L2B);
    localparam int unsigned BEATS = 1 << L2B;

    logic             rst_n;
    logic [NI*DW-1:0] dat;
    logic             vld;
    logic             rdy_in;
    logic             clr;
    logic [DW-1:0]    avg;
    logic             avg_vld;
    logic             avg_rdy = 1'b1;
    int               stall_mode = 0;
    int               cyc = 0;
    logic [DW-1:0]    exp_q[$];
    longint           acc_m;
    int               cnt_m;
    logic             use_dir;
    logic [DW-1:0]    dir_exp;
    logic             seen;

    avg_n_per_clk_pipe #(
      .NUM_INPUTS (NI),
      .DWIDTH     (DW),
      .LOG2_BEATS (L2B),
      .SIGNED     (SG),
      .ROUND      (RD)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_dat_vector (dat),
      .i_dat_valid  (vld),
      .i_dat_ready  (rdy_in),
      .i_clear      (clr),
      .o_avg        (avg),
      .o_avg_valid  (avg_vld),
      .o_avg_ready  (avg_rdy)
    );

    // Consumer: random backpressure with a fixed 10-cycle low run every 60 cycles.
    always @(posedge clk) begin
      #1;
      cyc++;
      if (stall_mode == 0) avg_rdy = 1'b1;
      else if ((cyc % 60) >= 20 && (cyc % 60) < 30) avg_rdy = 1'b0;
      else avg_rdy = ($urandom_range(0, 2) != 0);
    end

    always @(negedge clk) begin
      if (rst_n === 1'b1) begin
        if (avg_vld && !avg_rdy) chk($sformatf("cfg%0d stall_ready", c), 32'(rdy_in), 0);
        if (avg_vld && avg_rdy) begin
          if (exp_q.size() == 0) begin
            bad($sformatf("cfg%0d unexpected_output 0x%0h", c, avg));
          end else begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            chk($sformatf("cfg%0d avg", c), 32'(avg), 32'(e));
          end
        end
      end
    end

    function automatic longint beat_sum(input logic [NI*DW-1:0] v);
      longint s;
      longint x;
      s = 0;
      for (int k = 0; k < NI; k++) begin
        x = longint'(v[k*DW +: DW]);
        if (SG != 0 && v[k*DW+DW-1]) x = x - (longint'(1) << DW);
        s += x;
      end
      return s;
    endfunction

    function automatic logic [DW-1:0] model_avg(input longint total);
      longint div;
      longint t;
      longint q;
      div = longint'(1) << S;
      t   = total + ((RD != 0) ? div / 2 : 0);
      q   = t / div;
      if (t < 0 && (t % div) != 0) q = q - 1;
      return q[DW-1:0];
    endfunction

    task automatic model_accept(input logic [NI*DW-1:0] v);
      acc_m += beat_sum(v);
      cnt_m++;
      if (cnt_m == BEATS) begin
        exp_q.push_back(use_dir ? dir_exp : model_avg(acc_m));
        acc_m = 0;
        cnt_m = 0;
      end
    endtask

    task automatic send_beat(input logic [NI*DW-1:0] v, input bit raw);
      int t;
      t   = 0;
      dat = v;
      vld = 1'b1;
      forever begin
        @(negedge clk);
        if (rdy_in) break;
        t++;
        if (t > 500) begin
          bad($sformatf("cfg%0d input_accept_timeout", c));
          vld = 1'b0;
          return;
        end
      end
      @(posedge clk);
      if (!raw) model_accept(v);
      #1;
      vld = 1'b0;
    endtask

    task automatic send_group(input logic [NI*DW-1:0] v, input logic [DW-1:0] inc,
                              input logic [DW-1:0] e, input bit measure);
      logic [NI*DW-1:0] b_v;
      int n;
      use_dir = 1'b1;
      dir_exp = e;
      for (int b = 0; b < BEATS; b++) begin
        for (int k = 0; k < NI; k++) b_v[k*DW +: DW] = v[k*DW +: DW] + DW'(b) * inc;
        send_beat(b_v, 1'b0);
      end
      use_dir = 1'b0;
      if (measure) begin
        n = 1;
        while (!avg_vld && n < 20) begin
          @(posedge clk);
          #1;
          n++;
        end
        chk($sformatf("cfg%0d latency", c), 32'(n), 5);
      end
    endtask

    task automatic wait_drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 2000) begin
        @(posedge clk);
        t++;
      end
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("cfg%0d drained", c), 32'(exp_q.size()), 0);
    endtask

    initial begin
      logic [NI*DW-1:0] rv;
      rst_n   = 1'b0;
      vld     = 1'b0;
      clr     = 1'b0;
      dat     = '0;
      acc_m   = 0;
      cnt_m   = 0;
      use_dir = 1'b0;
      dir_exp = '0;
      seen    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("cfg%0d reset_avg", c), 32'(avg), 0);
      chk($sformatf("cfg%0d reset_valid", c), 32'(avg_vld), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk($sformatf("cfg%0d reset_ready", c), 32'(rdy_in), 1);
      @(posedge clk);
      #1;

      send_group(mk(16'h0010, 16'h0010, 0), 16'h0, 16'h0010, 1'b1);
      case (c)
        0: begin
          send_group(mk(16'h0000, 16'h0008, 15), 16'h0, 16'h0000, 1'b0);
          send_group(mk(16'hFFFF, 16'hFFFF, 0), 16'h0, 16'hFFFF, 1'b0);
        end
        1: begin
          send_group(mk(16'hFFFE, 16'h0001, 8), 16'h0, 16'h0000, 1'b0);
          send_group(mk(16'h0000, 16'h0008, 15), 16'h0, 16'h0001, 1'b0);
          send_group(mk(16'hFFFF, 16'hFFFF, 0), 16'h0, 16'hFFFF, 1'b0);
        end
        2: begin
          send_group(mk(16'h0004, 16'h0004, 0), 16'h4, 16'h000A, 1'b0);
          send_group(mk(16'hFFFF, 16'hFFFF, 0), 16'h0, 16'hFFFF, 1'b0);
          send_group(mk(16'h0000, 16'h0008, 15), 16'h0, 16'h0001, 1'b0);
        end
        default: begin
          send_group(mk(16'hFFFE, 16'h0001, 8), 16'h0, 16'hFFFF, 1'b0);
          send_group(mk(16'hFFFF, 16'hFFFF, 0), 16'h0, 16'hFFFF, 1'b0);
          send_group(mk(16'h0000, 16'h0008, 15), 16'h0, 16'h0000, 1'b0);
        end
      endcase
      wait_drain();

      // Two beats in flight are flushed by a one-cycle clear.
      send_beat(mk(16'h0030, 16'h0030, 0), 1'b1);
      send_beat(mk(16'h0030, 16'h0030, 0), 1'b1);
      clr = 1'b1;
      @(negedge clk);
      chk($sformatf("cfg%0d clear_ready", c), 32'(rdy_in), 0);
      @(posedge clk);
      #1;
      clr = 1'b0;
      send_group(mk(16'h0020, 16'h0020, 0), 16'h0, 16'h0020, 1'b0);
      wait_drain();

      stall_mode = 1;
      for (int g = 0; g < int'(NRAND); g++) begin
        for (int b = 0; b < int'(BEATS); b++) begin
          for (int k = 0; k < int'(NI); k++) rv[k*DW +: DW] = DW'($urandom);
          send_beat(rv, 1'b0);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
      end
      stall_mode = 0;
      wait_drain();

      // Asynchronous reset in the middle of a partial group.
      send_group(mk(16'h0020, 16'h0020, 0), 16'h0, 16'h0020, 1'b0);
      wait_drain();
      send_beat(mk(16'h0010, 16'h0010, 0), 1'b1);
      send_beat(mk(16'h0010, 16'h0010, 0), 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk($sformatf("cfg%0d midreset_avg", c), 32'(avg), 0);
      chk($sformatf("cfg%0d midreset_valid", c), 32'(avg_vld), 0);
      exp_q.delete();
      acc_m = 0;
      cnt_m = 0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (avg_vld) seen = 1'b1;
      end
      chk($sformatf("cfg%0d post_reset_idle", c), 32'(seen), 0);
      mark_done();
    end
  end

  initial begin
    int t;
    t = 0;
    while (n_done < int'(NCFG) && t < 60000) begin
      @(posedge clk);
      t++;
    end
    chk("all_configs_done", 32'(n_done), NCFG);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
